serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// Bit-serial adder: sequences one full adder over WIDTH operand bits, LSB first.
// Latency: done pulses WIDTH edges after the accepting edge; busy high for WIDTH cycles.
// Backpressure: start is ignored while busy; it is accepted again in the done cycle.

// Single-bit full adder built from gate-level primitives expressed as assigns.
module hierarchy_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ab_x & cin;
  assign sum  = ab_x ^ cin;
  assign cout = ab_a | cx_a;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last;

  // The only arithmetic in the block: one full adder on the current LSBs.
  hierarchy_full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (c_reg),
    .sum  (fa_sum),
    .cout (fa_carry)
  );

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == LAST);

  // New sum bit enters at the MSB end; a 1-bit adder has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_s1
      assign s_next = fa_sum;
    end else begin : g_sn
      assign s_next = {fa_sum, s_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave IDLE on start, return after the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      c_reg <= fa_carry;
      cnt   <= cnt + CW'(1);
    end
  end

  // Status and result registers; the result only moves on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      done <= last;
      busy <= accept || ((state == RUN) && !last);
      if (last) begin
        sum  <= s_next;
        cout <= fa_carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// Bench for serial_adder at WIDTH=8 (vectors, corner sequences, random)
// and WIDTH=2 (exhaustive), all against plain-arithmetic expectations.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] last_s8;
  logic       last_c8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // One WIDTH=8 operation; reports result, done latency, busy cycles,
  // done count and protocol violations (done with busy, result moving early).
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     output logic [7:0] rs, output logic rc, output int lat,
                     output int bcy, output int nd, output int bad);
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = -1; bcy = 0; nd = 0; bad = 0; rs = '0; rc = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (busy8) bcy++;
      if (done8) begin
        nd++;
        if (busy8) bad++;
        if (lat < 0) begin
          lat = k; rs = sum8; rc = cout8;
        end
      end else if (lat < 0 && (sum8 !== last_s8 || cout8 !== last_c8)) begin
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                     output logic [1:0] rs, output logic rc, output int lat);
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = -1; rs = '0; rc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done2 && lat < 0) begin
        lat = k; rs = sum2; rc = cout2;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic [8:0] r;
    logic [1:0] rs2;
    logic       rc2;
    int lat, bcy, nd, bad, n;
    logic found;

    vt[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_w8", {busy8, done8, cout8, sum8}, 11'd0);
    chk("reset_w2", {busy2, done2, cout2, sum2}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_s8 = 8'h00; last_c8 = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].cin, rs, rc, lat, bcy, nd, bad);
      chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d_cout", i), rc, vt[i].c);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcy, 8);
      chk($sformatf("vec%0d_done_count", i), nd, 1);
      chk($sformatf("vec%0d_protocol", i), bad, 0);
      last_s8 = vt[i].s; last_c8 = vt[i].c;
    end

    // Start during the third busy cycle must be ignored.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0; rs = '0; rc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin
        if (nd == 0) begin rs = sum8; rc = cout8; end
        nd++;
      end
      @(negedge clk);
    end
    chk("ignored_start_sum", rs, 8'h7E);
    chk("ignored_start_cout", rc, 1'b0);
    chk("ignored_start_done_count", nd, 1);
    last_s8 = 8'h7E; last_c8 = 1'b0;

    // Back-to-back: new start held on the done cycle.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (done8) found = 1'b1;
      else @(negedge clk);
    end
    chk("b2b_first_done_seen", found, 1'b1);
    chk("b2b_first_sum", sum8, 8'h7E);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    found = 1'b0; n = -1; bad = 0;
    for (int k = 1; k <= 15 && !found; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (done8) begin
        found = 1'b1; n = k;
      end else if (sum8 !== 8'h7E || cout8 !== 1'b0) begin
        bad++;
      end
    end
    chk("b2b_second_gap", n, 9);
    chk("b2b_second_sum", sum8, 8'h03);
    chk("b2b_second_cout", cout8, 1'b0);
    chk("b2b_first_held", bad, 0);
    last_s8 = 8'h03; last_c8 = 1'b0;

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy8, 1'b1);
    chk("midrst_sum_before", sum8, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs_cleared", {busy8, done8, cout8, sum8}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    chk("midrst_no_done_after", nd, 0);
    chk("midrst_result_still_zero", {cout8, sum8}, 9'd0);
    last_s8 = 8'h00; last_c8 = 1'b0;

    // Randomised operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] x, y;
      logic c;
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      r = ref8(x, y, c);
      op8(x, y, c, rs, rc, lat, bcy, nd, bad);
      chk($sformatf("rand%0d_result", i), {rc, rs}, r);
      chk($sformatf("rand%0d_timing", i), {lat[7:0], bcy[7:0], nd[7:0], bad[7:0]},
          {8'd8, 8'd8, 8'd1, 8'd0});
      last_s8 = r[7:0]; last_c8 = r[8];
    end

    // Exhaustive WIDTH=2.
    for (int v = 0; v < 32; v++) begin
      logic [1:0] x, y;
      logic c;
      int e;
      x = v[4:3]; y = v[2:1]; c = v[0];
      e = int'(x) + int'(y) + int'(c);
      op2(x, y, c, rs2, rc2, lat);
      chk($sformatf("w2_%0d+%0d+%0d", x, y, c), {rc2, rs2}, e[2:0]);
      chk($sformatf("w2_%0d_latency", v), lat, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
